// File: rtl/vga_timing_gen.sv
// 640x480@60 VGA raster generator: scan counters, syncs, display enable, frame timing.
// Latency: hs/vs/blank/frame_start are registered decodes aligned with DrawX/DrawY; *_d lag by PIPE_DELAY clocks.
// Backpressure: none; free-running on every pixel clock, only reset stalls it.
module vga_timing_gen #(
  parameter int H_VISIBLE  = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_VISIBLE  = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int PIPE_DELAY = 2
) (
  input  logic        vga_clk,
  input  logic        reset,
  output logic [9:0]  DrawX,
  output logic [9:0]  DrawY,
  output logic        hs,
  output logic        vs,
  output logic        blank,
  output logic        hs_d,
  output logic        vs_d,
  output logic        blank_d,
  output logic        frame_start,
  output logic [15:0] frame_count
);

  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

  // Counter compare points, sized to the 10-bit scan counters.
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
  localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FP + V_SYNC);

  logic [9:0]  draw_x_q, draw_x_d;
  logic [9:0]  draw_y_q, draw_y_d;
  logic [15:0] frame_count_q, frame_count_d;
  logic        hsync_q, hsync_d;
  logic        vsync_q, vsync_d;
  logic        disp_en_q, disp_en_d;
  logic        fstart_q, fstart_d;

  // Next raster position and frame counter: x wraps every line, y wraps every frame.
  always_comb begin
    draw_x_d      = draw_x_q + 10'd1;
    draw_y_d      = draw_y_q;
    frame_count_d = frame_count_q;
    if (draw_x_q == H_LAST) begin
      draw_x_d = '0;
      if (draw_y_q == V_LAST) begin
        draw_y_d      = '0;
        frame_count_d = frame_count_q + 16'd1;
      end else begin
        draw_y_d = draw_y_q + 10'd1;
      end
    end
  end

  // Decode the next position so the registered strobes line up with the counters.
  always_comb begin
    hsync_d   = !((draw_x_d >= HS_START) && (draw_x_d < HS_END));
    vsync_d   = !((draw_y_d >= VS_START) && (draw_y_d < VS_END));
    disp_en_d = (draw_x_d < H_VIS) && (draw_y_d < V_VIS);
    fstart_d  = (draw_x_d == 10'd0) && (draw_y_d == 10'd0);
  end

  // Raster state; reset parks at (0,0) blanked with both syncs idle.
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      draw_x_q      <= '0;
      draw_y_q      <= '0;
      frame_count_q <= '0;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      disp_en_q     <= 1'b0;
      fstart_q      <= 1'b0;
    end else begin
      draw_x_q      <= draw_x_d;
      draw_y_q      <= draw_y_d;
      frame_count_q <= frame_count_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      disp_en_q     <= disp_en_d;
      fstart_q      <= fstart_d;
    end
  end

  assign DrawX       = draw_x_q;
  assign DrawY       = draw_y_q;
  assign hs          = hsync_q;
  assign vs          = vsync_q;
  assign blank       = disp_en_q;
  assign frame_start = fstart_q;
  assign frame_count = frame_count_q;

  // Delayed copies for renderers whose pixel data is registered through ROM and palette.
  if (PIPE_DELAY > 0) begin : g_pipe
    logic [PIPE_DELAY-1:0] hs_pipe_q, hs_pipe_d;
    logic [PIPE_DELAY-1:0] vs_pipe_q, vs_pipe_d;
    logic [PIPE_DELAY-1:0] bl_pipe_q, bl_pipe_d;

    // Shift each strobe one stage deeper per clock; stage 0 takes the live value.
    always_comb begin
      hs_pipe_d[0] = hsync_q;
      vs_pipe_d[0] = vsync_q;
      bl_pipe_d[0] = disp_en_q;
      for (int i = 1; i < PIPE_DELAY; i++) begin
        hs_pipe_d[i] = hs_pipe_q[i-1];
        vs_pipe_d[i] = vs_pipe_q[i-1];
        bl_pipe_d[i] = bl_pipe_q[i-1];
      end
    end

    // Reset clears the pipe to idle levels instead of draining stale pixels.
    always_ff @(posedge vga_clk or posedge reset) begin
      if (reset) begin
        hs_pipe_q <= '1;
        vs_pipe_q <= '1;
        bl_pipe_q <= '0;
      end else begin
        hs_pipe_q <= hs_pipe_d;
        vs_pipe_q <= vs_pipe_d;
        bl_pipe_q <= bl_pipe_d;
      end
    end

    assign hs_d    = hs_pipe_q[PIPE_DELAY-1];
    assign vs_d    = vs_pipe_q[PIPE_DELAY-1];
    assign blank_d = bl_pipe_q[PIPE_DELAY-1];
  end else begin : g_nopipe
    assign hs_d    = hsync_q;
    assign vs_d    = vsync_q;
    assign blank_d = disp_en_q;
  end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Generates the 640x480 @ 60 Hz VGA raster that every sprite renderer in the display path consumes. It drives the `DrawX`/`DrawY` scan coordinates, the `blank` display-enable and the active-low sync pulses. It also provides copies of the sync and `blank` signals delayed to line up with the registered output of the ROM-plus-palette renderers, and frame-level timing (`frame_start`, `frame_count`) for game-logic updates. It sits between the pixel-clock source and all `*_example`-style renderers and the VGA pins.

## Interface
- `H_VISIBLE`, 640, visible pixels per line
- `H_FP`, 16, horizontal front porch (clocks)
- `H_SYNC`, 96, horizontal sync width (clocks)
- `H_BP`, 48, horizontal back porch (clocks)
- `V_VISIBLE`, 480, visible lines per frame
- `V_FP`, 10, vertical front porch (lines)
- `V_SYNC`, 2, vertical sync width (lines)
- `V_BP`, 33, vertical back porch (lines)
- `PIPE_DELAY`, 2, delay in clocks for `hs_d`/`vs_d`/`blank_d`; legal range 0..8

Ports:
- `vga_clk`  in  1  pixel clock; the only clock
- `reset`  in  1  asynchronous, active-high
- `DrawX`  out  10  horizontal counter, 0..H_TOTAL-1 (H_TOTAL = sum of H params = 800)
- `DrawY`  out  10  vertical counter, 0..V_TOTAL-1 (V_TOTAL = 525)
- `hs`  out  1  horizontal sync, active low
- `vs`  out  1  vertical sync, active low
- `blank`  out  1  display enable; 1 = visible pixel
- `hs_d`, `vs_d`, `blank_d`  out  1 each  `hs`/`vs`/`blank` delayed by PIPE_DELAY clocks
- `frame_start`  out  1  one-clock pulse while `DrawX==0 && DrawY==0`
- `frame_count`  out  16  frames completed since reset

## Operation
- `DrawX` increments on every clock. At H_TOTAL-1 it wraps to 0, and `DrawY` then increments. When `DrawY` is also at V_TOTAL-1, it wraps to 0.
- `hs`, `vs`, `blank` and `frame_start` are registered decodes of the next counter value. Outside reset they are therefore valid for the same cycle as the `DrawX`/`DrawY` they describe. There is no combinational path from the counters to these outputs.
- `hs` = 0 for H_VISIBLE+H_FP ≤ DrawX < H_VISIBLE+H_FP+H_SYNC, which is 656..751 at defaults.
- `vs` = 0 for V_VISIBLE+V_FP ≤ DrawY < V_VISIBLE+V_FP+V_SYNC, which is 490..491 at defaults. `vs` changes state only on the same cycle that `DrawX` is 0.
- `blank` = 1 only for DrawX < H_VISIBLE and DrawY < V_VISIBLE.
- Delayed outputs use a PIPE_DELAY-deep shift register per signal. With PIPE_DELAY=0 they equal `hs`/`vs`/`blank` exactly.
- `frame_count` increments by 1 on the clock where the counters wrap from (799,524) to (0,0). It wraps from 65535 to 0.

## Timing
- Reset values:
  - DrawX=0, DrawY=0
  - hs=1, vs=1, blank=0, frame_start=0
  - every delay stage: hs/vs=1, blank=0
  - frame_count=0
- Reset is asynchronous on assertion. Outputs take reset values without a clock edge.
- Reset asserted mid-frame: the counters return to (0,0) immediately. The delay pipes are cleared rather than drained. `frame_count` clears.
- Behaviour after reset release:
  - On the first rising edge, the counters go to (1,0) and all decodes reflect (1,0).
  - The (0,0) pixel shown during reset is therefore blanked.
  - `frame_start` is not pulsed for the reset frame. The first pulse occurs at the first natural wrap, 420000 clocks after release.
- Line period is 800 clocks. Frame period is 420000 clocks.
- `blank` is high 640 clocks per visible line and low for all clocks of lines 480..524.
- Delayed outputs lag their sources by exactly PIPE_DELAY clocks, including across line and frame wraps.

## Test plan
- Reset check: assert reset for 3 clocks mid-frame at DrawX=300, DrawY=200. Required response:
  - all outputs at their reset values asynchronously
  - after release and the first edge, DrawX=1, DrawY=0, blank=1
- Horizontal timing: run one line. Required response:
  - `hs` falls on the DrawX=656 cycle and rises on DrawX=752
  - `blank` falls on DrawX=640 and rises on DrawX=0 of the next line
  - DrawX wraps 799→0 and DrawY increments on the same edge
- Vertical timing: run one full frame. Required response:
  - `vs` is low exactly for DrawY 490..491 (1600 clocks)
  - `blank` stays 0 throughout DrawY 480..524
  - DrawY wraps 524→0
- Frame counters: run 3 frames after reset. Required response:
  - `frame_start` is high only at (0,0), 3 single-cycle pulses spaced 420000 clocks apart
  - `frame_count` reads 1, 2, 3 on those cycles
  - force `frame_count` to 65535 and run one more wrap; it reads 0
- Delay alignment: for PIPE_DELAY of 0, 2 and 8, compare `blank_d`, `hs_d` and `vs_d` with `blank`, `hs` and `vs` sampled PIPE_DELAY clocks earlier; they match on every cycle of a frame.
- Non-default geometry: set H_VISIBLE=8, H_FP=2, H_SYNC=3, H_BP=2, V_VISIBLE=4, V_FP=1, V_SYNC=1, V_BP=1. Required response:
  - line period is 15 clocks and frame period is 105 clocks
  - `hs` is low for DrawX 10..12
  - `vs` is low for DrawY 5
